// File: rtl/ks_memory.sv
// ks_memory: unified 32x16 program/data memory for the K&S CPU.
// Boots the CPU from a load stream and dumps the image after halt.
module ks_memory #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic                  ram_write_enable,
  output logic [DATA_WIDTH-1:0] ram_rdata,
  input  logic                  halt,
  output logic                  cpu_rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic                  dump_last
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_A = '1;

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    DUMP,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] lptr;
  logic [ADDR_WIDTH-1:0] dptr;

  logic                  load_fire;
  logic                  dump_adv;
  logic                  dump_end;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign load_ready = (state == LOAD);
  assign load_fire  = load_valid && load_ready;
  assign dump_adv   = (state == DUMP) && (!dump_valid || dump_ready);
  assign dump_end   = dump_adv && dump_valid && dump_last;

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD: begin
        if (load_fire && (load_last || lptr == LAST_A))
          state_nx = RUN;
      end
      RUN: begin
        if (halt)
          state_nx = DUMP;
      end
      DUMP: begin
        if (dump_end)
          state_nx = DONE;
      end
      DONE: state_nx = DONE;
      default: state_nx = LOAD;
    endcase
  end

  // Single write port: loader in LOAD, CPU in RUN, frozen otherwise
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = lptr;
    mem_wdata = load_data;
    if (load_fire) begin
      mem_we = 1'b1;
    end else if (state == RUN && ram_write_enable) begin
      mem_we    = 1'b1;
      mem_waddr = ram_addr;
      mem_wdata = ram_wdata;
    end
  end

  // Array is never reset so unloaded words survive a reboot
  always_ff @(posedge clk) begin
    if (mem_we && !rst)
      mem[mem_waddr] <= mem_wdata;
  end

  // Control state, pointers, CPU reset and CPU read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      lptr      <= '0;
      dptr      <= '0;
      cpu_rst_n <= 1'b0;
      ram_rdata <= '0;
    end else begin
      state <= state_nx;
      if (load_fire && lptr != LAST_A)
        lptr <= lptr + 1'b1;
      if (state_nx == RUN)
        cpu_rst_n <= 1'b1;
      if (state == RUN)
        ram_rdata <= mem[ram_addr];
      if (state == RUN && halt)
        dptr <= '0;
      else if (dump_adv && !dump_end)
        dptr <= dptr + 1'b1;
    end
  end

  // Dump output register; holds while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_addr  <= '0;
      dump_last  <= 1'b0;
    end else if (dump_end) begin
      dump_valid <= 1'b0;
    end else if (dump_adv) begin
      dump_valid <= 1'b1;
      dump_data  <= mem[dptr];
      dump_addr  <= dptr;
      dump_last  <= (dptr == LAST_A);
    end
  end

endmodule

// File: tb/tb_ks_memory.sv
// tb_ks_memory: directed bench for ks_memory with a
// phase-level reference model and per-cycle output compare.
module tb_ks_memory;

  localparam int P_LOAD = 0;
  localparam int P_RUN  = 1;
  localparam int P_DUMP = 2;
  localparam int P_DONE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  ram_addr = '0;
  logic [15:0] ram_wdata = '0;
  logic        ram_write_enable = 1'b0;
  logic [15:0] ram_rdata;
  logic        halt = 1'b0;
  logic        cpu_rst_n;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [15:0] dump_data;
  logic [4:0]  dump_addr;
  logic        dump_last;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  logic [15:0] mm [32];
  int          phase = P_LOAD;
  int          lcnt = 0;
  int          dcyc = 0;
  int          dq_addr = 0;
  logic [15:0] exp_rdata = '0;

  // monitor state
  bit          mon_en = 0;
  bit          pv_stall = 0;
  logic [15:0] p_data;
  logic [4:0]  p_addr;
  logic        p_last;
  int          acc_cnt = 0;
  logic [15:0] cap [32];

  ks_memory dut (
    .clk              (clk),
    .rst              (rst),
    .ram_addr         (ram_addr),
    .ram_wdata        (ram_wdata),
    .ram_write_enable (ram_write_enable),
    .ram_rdata        (ram_rdata),
    .halt             (halt),
    .cpu_rst_n        (cpu_rst_n),
    .load_valid       (load_valid),
    .load_ready       (load_ready),
    .load_data        (load_data),
    .load_last        (load_last),
    .dump_valid       (dump_valid),
    .dump_ready       (dump_ready),
    .dump_data        (dump_data),
    .dump_addr        (dump_addr),
    .dump_last        (dump_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: memory image, phase and expected read data
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     = P_LOAD;
      lcnt      = 0;
      dcyc      = 0;
      dq_addr   = 0;
      exp_rdata = '0;
    end else begin
      case (phase)
        P_LOAD: begin
          if (load_valid) begin
            mm[lcnt] = load_data;
            lcnt++;
            if (load_last || lcnt == 32) phase = P_RUN;
          end
        end
        P_RUN: begin
          exp_rdata = mm[ram_addr];
          if (ram_write_enable) mm[ram_addr] = ram_wdata;
          if (halt) begin
            phase   = P_DUMP;
            dcyc    = 0;
            dq_addr = 0;
          end
        end
        P_DUMP: begin
          if (dcyc >= 1 && dump_ready) begin
            if (dq_addr == 31) phase = P_DONE;
            dq_addr++;
          end
          dcyc++;
        end
        default: ;
      endcase
    end
  end

  // Compare DUT outputs against the model every cycle
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      chk("cpu_rst_n", cpu_rst_n, phase != P_LOAD);
      chk("load_ready", load_ready, phase == P_LOAD);
      chk("ram_rdata", ram_rdata, exp_rdata);
      chk("dump_valid", dump_valid, phase == P_DUMP && dcyc >= 1);
      if (dump_valid) begin
        chk("dump_addr", dump_addr, dq_addr);
        chk("dump_data", dump_data, mm[dq_addr[4:0]]);
        chk("dump_last", dump_last, dq_addr == 31);
      end
      if (pv_stall) begin
        chk("hold_data", dump_data, p_data);
        chk("hold_addr", dump_addr, p_addr);
        chk("hold_last", dump_last, p_last);
      end
      pv_stall = dump_valid && !dump_ready;
      p_data   = dump_data;
      p_addr   = dump_addr;
      p_last   = dump_last;
      if (dump_valid && dump_ready) begin
        acc_cnt++;
        cap[dump_addr] = dump_data;
      end
    end else begin
      pv_stall = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1: asserts rst mid-cycle, checks async values
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_rdata", ram_rdata, 16'h0);
    chk("rst_cpu_rst_n", cpu_rst_n, 1'b0);
    chk("rst_load_ready", load_ready, 1'b1);
    chk("rst_dump_valid", dump_valid, 1'b0);
    chk("rst_dump_data", dump_data, 16'h0);
    chk("rst_dump_addr", dump_addr, 5'd0);
    chk("rst_dump_last", dump_last, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
  endtask

  task automatic load_word(input logic [15:0] d, input logic last,
                           input int gap);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic dump_all(input bit rnd);
    acc_cnt = 0;
    for (int i = 0; i < 32; i++) cap[i] = '0;
    for (int c = 0; c < 400 && phase != P_DONE; c++) begin
      dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    dump_ready = 1'b0;
    chk("dump_done", phase, P_DONE);
    tick();
    chk("dump_count", acc_cnt, 32);
  endtask

  initial begin
    tick();
    do_reset();
    mon_en = 1;
    tick();
    chk("ready_after_rst", load_ready, 1'b1);

    // full load, no last; CPU writes in LOAD must be ignored
    for (int i = 0; i < 32; i++) begin
      load_valid       = 1'b1;
      load_data        = 16'hA000 | 16'(i);
      load_last        = 1'b0;
      ram_write_enable = 1'b1;
      ram_addr         = 5'd20;
      ram_wdata        = 16'hDEAD;
      if (i == 31) chk("cpu_rst_n_pre", cpu_rst_n, 1'b0);
      tick();
    end
    ram_write_enable = 1'b0;
    load_data        = 16'hFFFF;
    chk("no_33rd_ready", load_ready, 1'b0);
    chk("full_cpu_rst_n", cpu_rst_n, 1'b1);
    tick();
    tick();
    load_valid = 1'b0;

    // read-during-write returns old, next read sees new
    ram_addr         = 5'd7;
    ram_wdata        = 16'hBEEF;
    ram_write_enable = 1'b1;
    tick();
    chk("rdw_old", ram_rdata, 16'hA007);
    ram_write_enable = 1'b0;
    tick();
    chk("rdw_new", ram_rdata, 16'hBEEF);

    // halt with a same-cycle write that must commit
    halt             = 1'b1;
    ram_addr         = 5'd3;
    ram_wdata        = 16'h5A5A;
    ram_write_enable = 1'b1;
    tick();
    halt             = 1'b0;
    chk("dump_first_lat", dump_valid, 1'b0);
    ram_addr  = 5'd4;
    ram_wdata = 16'h0BAD;
    dump_all(1'b1);
    ram_write_enable = 1'b0;
    chk("d1_w0", cap[0], 16'hA000);
    chk("d1_w3", cap[3], 16'h5A5A);
    chk("d1_w4", cap[4], 16'hA004);
    chk("d1_w7", cap[7], 16'hBEEF);
    chk("d1_w20", cap[20], 16'hA014);
    chk("d1_w31", cap[31], 16'hA01F);
    repeat (3) tick();
    chk("done_valid", dump_valid, 1'b0);
    chk("done_ready", load_ready, 1'b0);
    chk("done_cpu", cpu_rst_n, 1'b1);

    // reboot with a short program and gaps in load_valid
    do_reset();
    load_word(16'h1111, 1'b0, 2);
    load_word(16'h2222, 1'b0, 1);
    load_valid = 1'b1;
    load_data  = 16'h3333;
    load_last  = 1'b1;
    chk("short_pre_rise", cpu_rst_n, 1'b0);
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("short_rise", cpu_rst_n, 1'b1);
    ram_addr = 5'd2;
    tick();
    chk("short_read2", ram_rdata, 16'h3333);

    // dump, then reset while word 10 is on the output
    halt = 1'b1;
    tick();
    halt = 1'b0;
    dump_ready = 1'b1;
    begin
      bit hit = 0;
      for (int c = 0; c < 100 && !hit; c++) begin
        tick();
        if (dump_valid && dump_addr == 5'd10) hit = 1;
      end
      chk("reach_addr10", hit, 1'b1);
    end
    dump_ready = 1'b0;
    do_reset();

    // reload two words; older words must persist
    load_word(16'h7777, 1'b0, 0);
    load_word(16'h8888, 1'b1, 1);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    dump_all(1'b0);
    chk("d2_w0", cap[0], 16'h7777);
    chk("d2_w1", cap[1], 16'h8888);
    chk("d2_w2", cap[2], 16'h3333);
    chk("d2_w3", cap[3], 16'h5A5A);
    chk("d2_w7", cap[7], 16'hBEEF);
    chk("d2_w31", cap[31], 16'hA01F);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
